octant_rom_arbiter: RTL and testbench

OCTANT_ROM_ARBITER -- requirements
Module: octant_rom_arbiter

---
 rtl/rt_pkg.sv | 12 +
 rtl/rr_picker.sv | 32 +++
 rtl/octant_rom_arbiter.sv | 81 ++++++++
 tb/tb_octant_rom_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared defaults and helpers for the octant ROM arbiter.
// Requester indices are sized by idx_w() so that two requesters still get one bit.
package rt_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority select: the first eligible index at or after ptr,
// wrapping modulo N, returned both one-hot and as a binary index.
module rr_picker
  import rt_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int p;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    p   = 0;
    for (int k = 0; k < N; k++) begin
      p = (int'(ptr) + k) % N;
      if (!any && eligible[p]) begin
        any    = 1'b1;
        gnt[p] = 1'b1;
        idx    = IW'(p);
      end
    end
  end

endmodule

// File: rtl/octant_rom_arbiter.sv
// Round-robin arbiter giving NUM_REQ ray processors shared read access to the
// octant ROM; one read per requester in flight, data returned ROM_LAT cycles later.
module octant_rom_arbiter
  import rt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [DATA_W-1:0]              rdata,
  output logic                           rom_ren,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [DATA_W-1:0]              rom_dout
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0]      rr_ptr_reg;
  logic [NUM_REQ-1:0] outstanding_reg;
  logic [NUM_REQ-1:0] eligible;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [ROM_LAT-1:0] sr_vld_reg;
  logic [IW-1:0]      sr_idx_reg [ROM_LAT];

  // Gating with reset keeps the combinational outputs quiet while reset is held.
  assign eligible = reset ? '0 : (req & ~outstanding_reg);

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .eligible (eligible),
    .ptr      (rr_ptr_reg),
    .gnt      (gnt),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  assign rom_ren  = pick_any;
  assign rom_addr = pick_any ? req_addr[pick_idx] : '0;
  assign rdata    = rom_dout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
      assign rvalid[gi] = sr_vld_reg[ROM_LAT-1] && (sr_idx_reg[ROM_LAT-1] == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg      <= '0;
      outstanding_reg <= '0;
      sr_vld_reg      <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        sr_idx_reg[k] <= '0;
      end
    end else begin
      // A requester cannot be granted while outstanding, so set and clear never collide.
      outstanding_reg <= (outstanding_reg | gnt) & ~rvalid;
      if (pick_any) begin
        rr_ptr_reg <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
      sr_vld_reg[0] <= pick_any;
      sr_idx_reg[0] <= pick_idx;
      for (int k = 1; k < ROM_LAT; k++) begin
        sr_vld_reg[k] <= sr_vld_reg[k-1];
        sr_idx_reg[k] <= sr_idx_reg[k-1];
      end
    end
  end

endmodule

// File: tb/tb_octant_rom_arbiter.sv
// Bench for octant_rom_arbiter: two instances (ROM latency 1 and 3), directed
// scenarios followed by random requests, all checked against a cycle-level model.
module tb_octant_rom_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst1, rst3;
  logic [N-1:0]        req1, req3;
  logic [N-1:0][31:0]  addr1, addr3;
  logic [N-1:0]        gnt1, gnt3, rv1, rv3;
  logic [31:0]         rd1, rd3, ra1, ra3, dout1, dout3;
  logic                ren1, ren3;

  octant_rom_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .ROM_LAT(1)) dut1 (
    .clk(clk), .reset(rst1), .req(req1), .req_addr(addr1), .gnt(gnt1),
    .rvalid(rv1), .rdata(rd1), .rom_ren(ren1), .rom_addr(ra1), .rom_dout(dout1)
  );

  octant_rom_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .ROM_LAT(3)) dut3 (
    .clk(clk), .reset(rst3), .req(req3), .req_addr(addr3), .gnt(gnt3),
    .rvalid(rv3), .rdata(rd3), .rom_ren(ren3), .rom_addr(ra3), .rom_dout(dout3)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0C7A_17E5;
  endfunction

  // Octant ROM stand-ins with one and three cycles of read latency.
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    dout1 <= rom_f(ra1);
    p3[0] <= rom_f(ra3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dout3 = p3[2];

  logic         sel;
  logic [N-1:0] o_gnt, o_rv;
  logic [31:0]  o_rd, o_addr;
  logic         o_ren;
  assign o_gnt  = sel ? gnt3 : gnt1;
  assign o_rv   = sel ? rv3  : rv1;
  assign o_rd   = sel ? rd3  : rd1;
  assign o_addr = sel ? ra3  : ra1;
  assign o_ren  = sel ? ren3 : ren1;

  // Reference model: last grant cycle per requester (-1 = idle), pointer, cycle count.
  int          lat, mptr, cyc;
  int          gcyc [N];
  logic [31:0] gaddr [N];
  int          waitc [N];
  int          checks, failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d sel=%0d", tag, obs, exp, cyc, sel);
    end
  endtask

  task automatic model_reset();
    mptr = 0;
    cyc  = 0;
    for (int i = 0; i < N; i++) begin
      gcyc[i]  = -1;
      gaddr[i] = '0;
      waitc[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst1 = 1'b1; rst3 = 1'b1; req1 = '0; req3 = '0;
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0][31:0] a, output logic [N-1:0] g);
    logic [N-1:0] eg, erv;
    logic [31:0]  ea, ed;
    int           found, p;
    @(negedge clk);
    if (sel) begin req3 = r; addr3 = a; req1 = '0; end
    else     begin req1 = r; addr1 = a; req3 = '0; end
    #1;
    eg = '0; erv = '0; ea = '0; ed = '0; found = -1;
    for (int i = 0; i < N; i++) begin
      if (gcyc[i] >= 0 && gcyc[i] + lat == cyc) begin
        erv[i] = 1'b1;
        ed     = rom_f(gaddr[i]);
      end
    end
    for (int k = 0; k < N; k++) begin
      p = (mptr + k) % N;
      if (found < 0 && r[p] && gcyc[p] < 0) found = p;
    end
    if (found >= 0) begin
      eg[found] = 1'b1;
      ea        = a[found];
    end
    chk("gnt", 32'(o_gnt), 32'(eg));
    chk("rom_ren", 32'(o_ren), 32'(found >= 0));
    chk("rom_addr", o_addr, ea);
    chk("rvalid", 32'(o_rv), 32'(erv));
    if (erv != '0) chk("rdata", o_rd, ed);
    for (int i = 0; i < N; i++) begin
      if (r[i] && gcyc[i] < 0) begin
        if (o_gnt[i]) begin
          chk("wait_bound", 32'(waitc[i] < N), 32'd1);
          waitc[i] = 0;
        end else begin
          waitc[i]++;
        end
      end else begin
        waitc[i] = 0;
      end
    end
    for (int i = 0; i < N; i++) if (erv[i]) gcyc[i] = -1;
    if (found >= 0) begin
      gcyc[found]  = cyc;
      gaddr[found] = a[found];
      mptr         = (found + 1) % N;
    end
    cyc++;
    g = eg;
  endtask

  logic [N-1:0]       g, pend;
  logic [N-1:0][31:0] av;

  initial begin
    checks = 0; failures = 0;
    sel = 1'b0; lat = 1;
    rst1 = 1'b1; rst3 = 1'b1;
    req1 = '0; req3 = '0; addr1 = '0; addr3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    req1 = 4'hF; req3 = 4'hF;
    addr1 = {32'h33, 32'h22, 32'h11, 32'h44};
    addr3 = addr1;
    #1;
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_ren1", 32'(ren1), 32'd0);
    chk("rst_addr1", ra1, 32'd0);
    chk("rst_rvalid1", 32'(rv1), 32'd0);
    chk("rst_gnt3", 32'(gnt3), 32'd0);
    chk("rst_ren3", 32'(ren3), 32'd0);
    chk("rst_rvalid3", 32'(rv3), 32'd0);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0; req1 = '0; req3 = '0;
    model_reset();

    // All four requesting with distinct addresses: grants rotate 0,1,2,3.
    av = {32'h4000_0300, 32'h4000_0200, 32'h4000_0100, 32'h4000_0000};
    repeat (6) step(4'b1111, av, g);
    repeat (2) step(4'b0000, av, g);

    // Lone requester: one grant every ROM_LAT+1 cycles.
    av = {32'h0, 32'h0, 32'h0, 32'h0000_ABC0};
    repeat (6) step(4'b0001, av, g);

    // Pointer parked at 2 with requesters 0 and 1: 0 wins first, then 1.
    do_reset();
    av = {32'h0, 32'h0, 32'h0000_0B00, 32'h0000_0A00};
    step(4'b0010, av, g);
    step(4'b0000, av, g);
    step(4'b0011, av, g);
    chk("ptr_wrap_gnt0", 32'(g), 32'b0001);
    step(4'b0011, av, g);
    chk("ptr_next_gnt1", 32'(g), 32'b0010);

    // Three-cycle ROM: requesters 1 and 2 back to back, no early re-grant.
    sel = 1'b1; lat = 3;
    do_reset();
    av = {32'h0, 32'h0000_2222, 32'h0000_1111, 32'h0};
    repeat (7) step(4'b0110, av, g);
    repeat (4) step(4'b0000, av, g);

    // Reset one cycle after a grant drops the in-flight read.
    do_reset();
    av = {32'h0, 32'h0000_7777, 32'h0, 32'h0};
    step(4'b0100, av, g);
    chk("pre_reset_gnt2", 32'(g), 32'b0100);
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    chk("mid_reset_rvalid", 32'(rv3), 32'd0);
    chk("mid_reset_gnt", 32'(gnt3), 32'd0);
    model_reset();
    @(negedge clk);
    chk("held_reset_rvalid", 32'(rv3), 32'd0);
    rst3 = 1'b0; req3 = '0;
    repeat (4) step(4'b0000, av, g);
    av = {32'h0000_0D00, 32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00};
    step(4'b1111, av, g);
    chk("post_reset_gnt0", 32'(g), 32'b0001);
    repeat (4) step(4'b0000, av, g);

    // Random requesters on both latencies; requests are held until granted,
    // with an occasional drop before grant.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      lat = (s == 0) ? 1 : 3;
      do_reset();
      pend = '0;
      av   = '0;
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            av[i]   = $urandom;
          end else if (pend[i] && $urandom_range(0, 19) == 0) begin
            pend[i] = 1'b0;
          end
        end
        step(pend, av, g);
        pend = pend & ~g;
      end
      repeat (5) step(4'b0000, av, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
